// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared state/action types and default cycle constants for the gap sequencer
package maze_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FOLLOW   = 2'd1,
        MANEUVER = 2'd2,
        HALT     = 2'd3
    } state_t;

    // Two-bit plan step, consumed LSB-first at each qualified gap
    typedef enum logic [1:0] {
        ACT_STOP   = 2'd0,
        ACT_VEER_R = 2'd1,
        ACT_VEER_L = 2'd2,
        ACT_TURN   = 2'd3
    } action_t;

    localparam int GAP_CYC_DEF     = 1024;
    localparam int REACQ_CYC_DEF   = 1024;
    localparam int TIMEOUT_CYC_DEF = 4194303;
    localparam int TMO_W           = 22;

endpackage

// File: rtl/line_qual.sv
// rtl/line_qual.sv - saturating consecutive-level qualifier with synchronous clear
module line_qual #(
    parameter int THRESH = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(THRESH + 1);
    localparam logic [W-1:0] CNT_MAX  = W'(THRESH);
    localparam logic [W-1:0] CNT_LAST = W'(THRESH - 1);

    logic [W-1:0] count;

    // Any break in the level restarts the run; the count parks at THRESH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || !en || !level) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the THRESH-th consecutive sampled cycle of the level
    assign hit = en && level && (count >= CNT_LAST);

endmodule

// File: rtl/gap_cmd_sequencer.sv
// rtl/gap_cmd_sequencer.sv - line-gap maneuver sequencer; optional GAP_TIMEOUT_EN maneuver timeout
module gap_cmd_sequencer
    import maze_pkg::*;
#(
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int REACQ_CYC   = REACQ_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        line_present,
    input  logic        BMPL_n,
    input  logic        BMPR_n,
    output logic        go,
    output logic        veer_left,
    output logic        veer_right,
    output logic        turn_around,
    output logic        buzz_en
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 4194303) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 22-bit maneuver timer");
    end

    state_t      state;
    logic [15:0] plan;
    logic        cmd_rdy_q;
    logic        accept;
    logic        bump;
    logic        gap_hit;
    logic        reacq_hit;
    logic        tmo_hit;
    logic        qual_clr;

    // A held cmd_rdy is acknowledged once, on its rising edge
    assign accept   = cmd_rdy && !cmd_rdy_q;
    assign bump     = ((state == FOLLOW) || (state == MANEUVER)) && (!BMPL_n || !BMPR_n);
    assign qual_clr = accept || bump || gap_hit || reacq_hit || tmo_hit;

    line_qual #(.THRESH(GAP_CYC)) u_gap_qual (
        .clk   (clk),
        .rst   (RST),
        .en    (state == FOLLOW),
        .level (!line_present),
        .clr   (qual_clr),
        .hit   (gap_hit)
    );

    line_qual #(.THRESH(REACQ_CYC)) u_reacq_qual (
        .clk   (clk),
        .rst   (RST),
        .en    (state == MANEUVER),
        .level (line_present),
        .clr   (qual_clr),
        .hit   (reacq_hit)
    );

`ifdef GAP_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            tmo_cnt <= '0;
        end else if ((state != MANEUVER) || qual_clr) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == MANEUVER) && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            plan        <= '0;
            cmd_rdy_q   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            go          <= 1'b0;
            veer_left   <= 1'b0;
            veer_right  <= 1'b0;
            turn_around <= 1'b0;
            buzz_en     <= 1'b0;
        end else begin
            cmd_rdy_q   <= cmd_rdy;
            clr_cmd_rdy <= accept;
            if (accept) begin
                plan <= cmd;
            end

            // Bump outranks a simultaneous accept; the command is still latched above
            if (bump || (!accept && tmo_hit)) begin
                state       <= HALT;
                go          <= 1'b0;
                veer_left   <= 1'b0;
                veer_right  <= 1'b0;
                turn_around <= 1'b0;
                buzz_en     <= 1'b1;
            end else if (accept) begin
                state       <= (cmd != 16'h0000) ? FOLLOW : IDLE;
                go          <= (cmd != 16'h0000);
                veer_left   <= 1'b0;
                veer_right  <= 1'b0;
                turn_around <= 1'b0;
                buzz_en     <= 1'b0;
            end else if (gap_hit) begin
                plan <= {2'b00, plan[15:2]};
                case (action_t'(plan[1:0]))
                    ACT_STOP: begin
                        state <= IDLE;
                        go    <= 1'b0;
                    end
                    ACT_VEER_R: begin
                        state      <= MANEUVER;
                        veer_right <= 1'b1;
                    end
                    ACT_VEER_L: begin
                        state     <= MANEUVER;
                        veer_left <= 1'b1;
                    end
                    ACT_TURN: begin
                        state       <= MANEUVER;
                        turn_around <= 1'b1;
                    end
                endcase
            end else if (reacq_hit) begin
                state       <= FOLLOW;
                veer_left   <= 1'b0;
                veer_right  <= 1'b0;
                turn_around <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gap_cmd_sequencer.sv
// tb/tb_gap_cmd_sequencer.sv - directed self-checking bench for gap_cmd_sequencer
module tb_gap_cmd_sequencer;

`ifdef GAP_TIMEOUT_EN
    localparam int TMO = 5000;
`else
    localparam int TMO = 4194303;
`endif

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy;
    logic        line_present = 1'b1;
    logic        BMPL_n = 1'b1;
    logic        BMPR_n = 1'b1;
    logic        go, veer_left, veer_right, turn_around, buzz_en;

    int passed = 0;
    int total  = 0;

    gap_cmd_sequencer #(
        .GAP_CYC     (1024),
        .REACQ_CYC   (1024),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .line_present (line_present),
        .BMPL_n       (BMPL_n),
        .BMPR_n       (BMPR_n),
        .go           (go),
        .veer_left    (veer_left),
        .veer_right   (veer_right),
        .turn_around  (turn_around),
        .buzz_en      (buzz_en)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    // {go, veer_left, veer_right, turn_around, buzz_en}
    function automatic logic [4:0] outs();
        return {go, veer_left, veer_right, turn_around, buzz_en};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_accept(input logic [15:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        tick();
        check("clr_pulse", 8'(clr_cmd_rdy), 8'h1);
        cmd_rdy = 1'b0;
        tick();
        check("clr_single", 8'(clr_cmd_rdy), 8'h0);
    endtask

    initial begin
        tick(2);
        check("reset_outs", {3'b0, outs()}, 8'h00);
        check("reset_clr", 8'(clr_cmd_rdy), 8'h0);
        RST = 1'b0;
        tick();
        check("idle_after_reset", {3'b0, outs()}, 8'h00);

        // turn-around on first gap, back to FOLLOW on reacquisition
        line_present = 1'b1;
        do_accept(16'h0003);
        check("t1_follow", {3'b0, outs()}, 8'h10);
        line_present = 1'b0;
        tick(1023);
        check("t1_gap_1023", {3'b0, outs()}, 8'h10);
        tick();
        check("t1_gap_1024", {3'b0, outs()}, 8'h12);
        line_present = 1'b1;
        tick(1023);
        check("t1_reacq_1023", {3'b0, outs()}, 8'h12);
        tick();
        check("t1_reacq_1024", {3'b0, outs()}, 8'h10);
        line_present = 1'b0;
        tick(1024);
        check("t1_empty_plan_idle", {3'b0, outs()}, 8'h00);

        // veer left once, then the exhausted plan stops at the next gap
        line_present = 1'b1;
        do_accept(16'h0002);
        line_present = 1'b0;
        tick(1024);
        check("t2_veer_left", {3'b0, outs()}, 8'h18);
        line_present = 1'b1;
        tick(1024);
        check("t2_reacq", {3'b0, outs()}, 8'h10);
        line_present = 1'b0;
        tick(1024);
        check("t2_idle", {3'b0, outs()}, 8'h00);
        BMPL_n = 1'b0;
        tick(5);
        check("t2_idle_ignores_bump", {3'b0, outs()}, 8'h00);
        BMPL_n = 1'b0;
        BMPL_n = 1'b1;

        // dropouts one cycle short of a gap never qualify
        line_present = 1'b1;
        do_accept(16'hAAAA);
        for (int i = 0; i < 3; i++) begin
            line_present = 1'b0;
            tick(1023);
            line_present = 1'b1;
            tick();
            check("t3_short_dropout", {3'b0, outs()}, 8'h10);
        end
        line_present = 1'b0;
        tick(1024);
        check("t3_full_gap", {3'b0, outs()}, 8'h18);

        // bump during maneuver halts; only a command leaves HALT
        BMPR_n = 1'b0;
        tick();
        check("t4_bump_halt", {3'b0, outs()}, 8'h01);
        BMPR_n = 1'b1;
        tick(3);
        check("t4_halt_holds", {3'b0, outs()}, 8'h01);
        line_present = 1'b1;
        do_accept(16'h0001);
        check("t4_resume", {3'b0, outs()}, 8'h10);

        // bump and command in the same cycle
        BMPL_n  = 1'b0;
        cmd     = 16'h0005;
        cmd_rdy = 1'b1;
        tick();
        check("t5_bump_wins", {3'b0, outs()}, 8'h01);
        check("t5_still_acked", 8'(clr_cmd_rdy), 8'h1);
        BMPL_n = 1'b1;

        // held cmd_rdy yields one acknowledge per rising edge
        tick();
        check("t6_held_no_repulse", 8'(clr_cmd_rdy), 8'h0);
        cmd_rdy = 1'b0;
        tick();
        cmd     = 16'h0000;
        cmd_rdy = 1'b1;
        tick();
        check("t6_pulse", 8'(clr_cmd_rdy), 8'h1);
        check("t6_zero_cmd_idle", {3'b0, outs()}, 8'h00);
        tick();
        check("t6_held_2", 8'(clr_cmd_rdy), 8'h0);
        tick();
        check("t6_held_3", 8'(clr_cmd_rdy), 8'h0);
        cmd_rdy = 1'b0;
        tick();
        check("t6_stays_idle", {3'b0, outs()}, 8'h00);

`ifdef GAP_TIMEOUT_EN
        // maneuver with no reacquisition times out into HALT
        line_present = 1'b1;
        do_accept(16'h0003);
        line_present = 1'b0;
        tick(1024);
        check("t7_turn", {3'b0, outs()}, 8'h12);
        tick(4999);
        check("t7_before_timeout", {3'b0, outs()}, 8'h12);
        tick();
        check("t7_timeout_halt", {3'b0, outs()}, 8'h01);
`endif

        // reset mid-maneuver drops outputs without a clock edge
        line_present = 1'b1;
        do_accept(16'h0001);
        line_present = 1'b0;
        tick(1024);
        check("t8_veer_right", {3'b0, outs()}, 8'h14);
        #2;
        RST = 1'b1;
        #1;
        check("t8_async_reset", {3'b0, outs()}, 8'h00);
        tick();
        RST = 1'b0;
        line_present = 1'b1;
        tick(2);
        check("t8_idle_after_reset", {3'b0, outs()}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gap_cmd_sequencer.md
GAP_CMD_SEQUENCER -- requirements
Module: gap_cmd_sequencer

Interface
REQ-001 The module SHALL have parameter GAP_CYC, default 1024: consecutive line-absent cycles that qualify a gap.
REQ-002 The module SHALL have parameter REACQ_CYC, default 1024: consecutive line-present cycles that qualify line reacquisition.
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 4194303: maximum maneuver length in cycles, used only when GAP_TIMEOUT_EN is defined.
REQ-004 Port clk, input, 1: the only clock; all state SHALL change on its rising edge.
REQ-005 Port RST, input, 1: reset, asynchronous and active-high.
REQ-006 Port cmd, input, 16: travel plan word from the UART wrapper.
REQ-007 Port cmd_rdy, input, 1: cmd is valid, held high until cleared.
REQ-008 Port clr_cmd_rdy, output, 1: one-cycle pulse acknowledging cmd.
REQ-009 Port line_present, input, 1: IR line sensor result.
REQ-010 Port BMPL_n, input, 1: left bump switch, active-low.
REQ-011 Port BMPR_n, input, 1: right bump switch, active-low.
REQ-012 Port go, output, 1: motion enable to the line-follow controller.
REQ-013 Port veer_left, output, 1: active during a left-veer maneuver.
REQ-014 Port veer_right, output, 1: active during a right-veer maneuver.
REQ-015 Port turn_around, output, 1: active during a turn-around maneuver.
REQ-016 Port buzz_en, output, 1: obstacle/fault buzzer enable.

Function
REQ-017 The state machine SHALL use states IDLE, FOLLOW, MANEUVER and HALT; all outputs SHALL be registered.
REQ-018 On cmd_rdy=1 in any state, the module SHALL latch cmd into plan[15:0] and pulse clr_cmd_rdy for exactly one cycle, in the cycle after cmd_rdy is sampled.
REQ-019 After a cmd accept, next state SHALL be FOLLOW if cmd!=0 and IDLE if cmd==0; the accept SHALL clear any active maneuver output and buzz_en.
REQ-020 go SHALL be 1 in FOLLOW and MANEUVER and 0 in IDLE and HALT.
REQ-021 In FOLLOW, a gap SHALL be qualified when line_present=0 for GAP_CYC consecutive cycles; any 1 SHALL restart the count.
REQ-022 On a qualified gap, the module SHALL decode plan[1:0] and shift plan right by 2 with zero fill in the same cycle.
REQ-023 plan[1:0] decode: 00 -> IDLE; 01 -> MANEUVER with veer_right=1; 10 -> MANEUVER with veer_left=1; 11 -> MANEUVER with turn_around=1.
REQ-024 At most one maneuver output SHALL be high in any cycle.
REQ-025 In MANEUVER, the active maneuver output SHALL hold until line_present=1 for REACQ_CYC consecutive cycles, then clear in the cycle the module returns to FOLLOW.
REQ-026 If BMPL_n=0 or BMPR_n=0 in FOLLOW or MANEUVER, the module SHALL enter HALT next cycle with go=0, maneuver outputs 0 and buzz_en=1.
REQ-027 HALT SHALL be left only by a cmd accept.
REQ-028 If a bump and cmd_rdy occur in the same cycle, the bump SHALL win; cmd SHALL still be acknowledged and latched, and the state SHALL be HALT.
REQ-029 In IDLE, line_present and the bump inputs SHALL be ignored.
REQ-030 The qualification counters SHALL saturate at their threshold, never wrap, and SHALL clear on every state change.
REQ-031 After 8 qualified gaps, plan SHALL be 0, so the 9th gap SHALL go to IDLE.

Reset
REQ-032 While RST=1, the module SHALL be in IDLE with plan=0, both counters=0 and every output 0; operation SHALL resume on the first clk edge after RST falls.
REQ-033 Reset asserted mid-maneuver SHALL drop all outputs asynchronously, without waiting for a clock edge.

Configuration
REQ-034 With macro GAP_TIMEOUT_EN defined, a 22-bit counter SHALL run in MANEUVER; when it reaches TIMEOUT_CYC, the module SHALL enter HALT with buzz_en=1.
REQ-035 Without GAP_TIMEOUT_EN, the timeout counter SHALL not exist and MANEUVER SHALL wait for reacquisition indefinitely.

Structure
REQ-036 Shared package maze_pkg SHALL hold the state enum, the 2-bit action typedef (ACT_STOP, ACT_VEER_R, ACT_VEER_L, ACT_TURN) and the default cycle constants.
REQ-037 Sub-module line_qual SHALL provide a parameterised saturating consecutive-level counter with a clear input; it SHALL be instantiated twice, once for gap and once for reacquisition.

Verification
REQ-038 cmd=16'h0003 accepted, line_present=0 for 1024 cycles -> turn_around=1 and go=1; line_present=1 for 1024 cycles -> FOLLOW, turn_around=0.
REQ-039 cmd=16'h0002, gap then reacquire, second gap -> veer_left once, then IDLE with go=0 at the second gap (plan=0).
REQ-040 cmd=16'hAAAA, 1023-cycle line dropouts repeated -> no maneuver output ever asserts.
REQ-041 BMPR_n=0 during MANEUVER -> next cycle go=0, buzz_en=1; cmd=16'h0001 -> FOLLOW, buzz_en=0.
REQ-042 cmd_rdy held 3 cycles -> exactly one clr_cmd_rdy pulse per rising of cmd_rdy; cmd=16'h0000 -> state stays IDLE.
REQ-043 With GAP_TIMEOUT_EN and TIMEOUT_CYC=5000, gap with line never restored -> HALT and buzz_en=1 at cycle 5000 of MANEUVER; RST pulse -> all outputs 0 immediately.
